// File: rtl/uart_tx.sv
// 8N1 UART transmitter: start bit, eight data bits LSB first, stop bit.
// One bit lasts BAUD_DIV clocks; tx_done is sticky until the next accepted trmt.
module uart_tx #(
  parameter int BAUD_DIV = 2604
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       trmt,
  input  logic [7:0] tx_data,
  output logic       TX,
  output logic       tx_done,
  output logic       busy
);

  typedef enum logic {IDLE, XMIT} state_t;

  localparam logic [11:0] BAUD_LAST = 12'(BAUD_DIV - 1);
  localparam logic [3:0]  LAST_BIT  = 4'd9;

  state_t      state_q, state_d;
  logic [8:0]  shift_q, shift_d;
  logic [3:0]  bit_cnt_q, bit_cnt_d;
  logic [11:0] baud_cnt_q, baud_cnt_d;
  logic        done_q, done_d;
  logic        busy_q, busy_d;
  logic        shift_evt;

  assign shift_evt = (baud_cnt_q == BAUD_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      shift_q    <= 9'h1FF;
      bit_cnt_q  <= 4'd0;
      baud_cnt_q <= 12'd0;
      done_q     <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      bit_cnt_q  <= bit_cnt_d;
      baud_cnt_q <= baud_cnt_d;
      done_q     <= done_d;
      busy_q     <= busy_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (trmt) state_d = XMIT;
      XMIT:    if (shift_evt && bit_cnt_q == LAST_BIT) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    shift_d    = shift_q;
    bit_cnt_d  = bit_cnt_q;
    baud_cnt_d = baud_cnt_q;
    done_d     = done_q;
    busy_d     = busy_q;
    case (state_q)
      IDLE: begin
        if (trmt) begin
          shift_d    = {tx_data, 1'b0};
          bit_cnt_d  = 4'd0;
          baud_cnt_d = 12'd0;
          done_d     = 1'b0;
          busy_d     = 1'b1;
        end
      end
      XMIT: begin
        if (shift_evt) begin
          // Ones shifted in at the top become the stop bit and idle level.
          baud_cnt_d = 12'd0;
          shift_d    = {1'b1, shift_q[8:1]};
          bit_cnt_d  = bit_cnt_q + 4'd1;
          if (bit_cnt_q == LAST_BIT) begin
            bit_cnt_d = 4'd0;
            done_d    = 1'b1;
            busy_d    = 1'b0;
          end
        end else begin
          baud_cnt_d = baud_cnt_q + 12'd1;
        end
      end
      default: ;
    endcase
  end

  assign TX      = shift_q[0];
  assign tx_done = done_q;
  assign busy    = busy_q;

endmodule

// File: tb/tb_uart_tx.sv
// Scoreboard bench for uart_tx: stimulus queues expected bytes, a line monitor
// decodes TX per bit time and checks frame timing, busy and tx_done.
module tb_uart_tx;
  localparam int B = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       trmt = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       TX, tx_done, busy;

  uart_tx #(.BAUD_DIV(B)) dut (
    .clk(clk), .rst_n(rst_n), .trmt(trmt), .tx_data(tx_data),
    .TX(TX), .tx_done(tx_done), .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {logic [7:0] d; int gap;} exp_t;
  exp_t q[$];

  int n_chk = 0, n_fail = 0;
  bit end_req = 1'b0;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", nm, act, exp, cyc);
    end
  endtask

  // Monitor: frame word {stop, data, start}; sample s of the frame carries bit s/B.
  bit         in_frame = 1'b0, rogue = 1'b0, prev_rst = 1'b0;
  logic       done_exp = 1'b0;
  logic [9:0] fw = '1;
  int         s = 0, last_start = -1000;
  exp_t       e;

  initial begin
    forever begin
      @(negedge clk or negedge rst_n);
      if (!rst_n && prev_rst) begin
        #1;
        if (in_frame) begin
          chk("async_rst_tx", TX, 1);
          chk("async_rst_busy", busy, 0);
          chk("async_rst_done", tx_done, 0);
        end
        in_frame = 0; rogue = 0; done_exp = 0; prev_rst = 0;
      end else if (!rst_n) begin
        if (cyc > 0) begin
          chk("reset_tx", TX, 1);
          chk("reset_busy", busy, 0);
          chk("reset_done", tx_done, 0);
        end
        in_frame = 0; done_exp = 0;
      end else begin
        prev_rst = 1;
        if (end_req) begin
          chk("queue_drained", q.size(), 0);
          chk("end_idle", {31'd0, in_frame}, 0);
          $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
          $finish;
        end
        if (rogue) begin
          if (busy === 1'b0 && TX === 1'b1) rogue = 0;
        end else if (!in_frame && TX === 1'b0) begin
          if (q.size() == 0) begin
            chk("unexpected_frame_start", q.size(), 1);
            rogue = 1;
          end else begin
            e = q.pop_front();
            fw = {1'b1, e.d, 1'b0};
            if (e.gap != 0) chk("start_to_start", cyc - last_start, e.gap);
            last_start = cyc;
            in_frame = 1;
            s = 0;
          end
        end
        if (in_frame) begin
          if (s < 10 * B) begin
            chk("tx_bit", TX, fw[s / B]);
            chk("busy_in_frame", busy, 1);
            chk("done_in_frame", tx_done, 0);
            s++;
          end else begin
            chk("done_rise", tx_done, 1);
            chk("busy_fall", busy, 0);
            chk("tx_after_stop", TX, 1);
            in_frame = 0;
            done_exp = 1;
          end
        end else if (!rogue) begin
          chk("idle_tx", TX, 1);
          chk("idle_busy", busy, 0);
          chk("idle_done", tx_done, done_exp);
        end
      end
    end
  end

  task automatic send(input logic [7:0] d, input int gap);
    tx_data = d;
    trmt = 1'b1;
    q.push_back('{d, gap});
    @(negedge clk);
    trmt = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy !== 1'b0) begin
      @(negedge clk);
      n++;
      if (n > 200) begin
        $display("FAIL wait_idle: busy stuck, got %b expected 0", busy);
        $fatal(1);
      end
    end
  endtask

  task automatic wait_done();
    int n = 0;
    while (tx_done !== 1'b1) begin
      @(negedge clk);
      n++;
      if (n > 200) begin
        $display("FAIL wait_done: tx_done never rose, got %b expected 1", tx_done);
        $fatal(1);
      end
    end
  endtask

  initial begin
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);

    send(8'hA5, 0);
    wait_done();

    // Back-to-back: second trmt in the first idle cycle after tx_done.
    send(8'h00, 0);
    wait_done();
    send(8'hFF, 10 * B + 1);
    wait_done();

    // trmt during a frame is ignored and tx_data is not resampled.
    send(8'h81, 0);
    repeat (5 * B) @(negedge clk);
    tx_data = 8'h3C;
    trmt = 1'b1;
    @(negedge clk);
    trmt = 1'b0;
    wait_done();
    repeat (60) @(negedge clk);

    // Asynchronous reset inside data bit 3, away from any clock edge.
    send(8'($urandom), 0);
    repeat (4 * B + 1) @(posedge clk);
    #2 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    send(8'h5A, 0);
    wait_done();

    // trmt held high across a frame end restarts on the first idle edge.
    wait_idle();
    tx_data = 8'($urandom);
    trmt = 1'b1;
    q.push_back('{tx_data, 0});
    q.push_back('{tx_data, 10 * B + 1});
    repeat (10 * B + 3) @(negedge clk);
    trmt = 1'b0;
    wait_done();

    for (int i = 0; i < 25; i++) begin
      wait_idle();
      repeat ($urandom_range(0, 3)) @(negedge clk);
      send(8'($urandom), 0);
      if ($urandom_range(0, 1) == 1) begin
        repeat ($urandom_range(2, 30)) @(negedge clk);
        tx_data = 8'($urandom);
        trmt = 1'b1;
        @(negedge clk);
        trmt = 1'b0;
      end
    end

    wait_idle();
    repeat (5) @(negedge clk);
    end_req = 1'b1;
    repeat (10) @(negedge clk);
    $display("FAIL monitor_finish: monitor did not end the run, got running expected finished");
    $fatal(1);
  end

endmodule
